// File: rtl/edge_pkg.sv
// Shared types and constants for the edge event serializer slice.
package edge_pkg;

  localparam int NBITS = 8;
  localparam int IDW = $clog2(NBITS);

  typedef logic [IDW-1:0] lane_id_t;

  localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

endpackage

// File: rtl/edge_rr_arbiter.sv
// Combinational round-robin search: first set request bit strictly after `last`, wrapping.
import edge_pkg::*;

module edge_rr_arbiter #(
  parameter int NBITS = edge_pkg::NBITS,
  localparam int IDW = $clog2(NBITS)
) (
  input  logic [NBITS-1:0] req,
  input  logic [IDW-1:0]   last,
  output logic [NBITS-1:0] gnt,
  output logic [IDW-1:0]   gnt_idx,
  output logic             any
);

  always_comb begin
    int idx;
    logic [IDW-1:0] idx_w;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    idx_w   = '0;
    // Offsets 1..NBITS so the previously granted lane is visited last.
    for (int k = 1; k <= NBITS; k++) begin
      idx   = (int'(last) + k) % NBITS;
      idx_w = idx[IDW-1:0];
      if (!any && req[idx_w]) begin
        any        = 1'b1;
        gnt[idx_w] = 1'b1;
        gnt_idx    = idx_w;
      end
    end
  end

endmodule

// File: rtl/edge_event_serializer.sv
// Serializes per-lane edge pulses into a round-robin valid/ready stream of lane IDs.
// Optional saturating drop counter (port drop_cnt) enabled by EDGE_SER_DROP_CNT_EN.
import edge_pkg::*;

module edge_event_serializer #(
  parameter int NBITS = edge_pkg::NBITS,
  localparam int IDW = $clog2(NBITS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] in_,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [IDW-1:0]   out_id
`ifdef EDGE_SER_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  localparam logic [IDW-1:0] LAST_RST = IDW'(NBITS - 1);

  logic [NBITS-1:0] pend_q, pend_d;
  logic             out_val_q, out_val_d;
  logic [IDW-1:0]   out_id_q, out_id_d;
  logic [IDW-1:0]   last_q, last_d;

  logic [NBITS-1:0] gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             any;
  logic             slot_free;
  logic [NBITS-1:0] grant_vec;

  edge_rr_arbiter #(.NBITS(NBITS)) u_arb (
    .req     (pend_q),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  always_comb begin
    slot_free = !out_val_q || out_rdy;
    grant_vec = slot_free ? gnt : '0;
    // A lane granted and pulsing on the same edge re-arms instead of dropping.
    pend_d    = (pend_q & ~grant_vec) | in_;
    out_val_d = out_val_q;
    out_id_d  = out_id_q;
    last_d    = last_q;
    if (slot_free) begin
      out_val_d = any;
      if (any) begin
        out_id_d = gnt_idx;
        last_d   = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q    <= '0;
      out_val_q <= 1'b0;
      out_id_q  <= '0;
      last_q    <= LAST_RST;
    end else begin
      pend_q    <= pend_d;
      out_val_q <= out_val_d;
      out_id_q  <= out_id_d;
      last_q    <= last_d;
    end
  end

  assign out_val = out_val_q;
  assign out_id  = out_id_q;

`ifdef EDGE_SER_DROP_CNT_EN
  logic [NBITS-1:0] drop_vec;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input int unsigned n);
    int unsigned s;
    s = 32'(a) + n;
    if (s > 32'(DROP_CNT_MAX)) return DROP_CNT_MAX;
    return s[7:0];
  endfunction

  always_comb begin
    drop_vec   = in_ & pend_q & ~grant_vec;
    drop_cnt_d = sat_add(drop_cnt_q, $countones(drop_vec));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
